// File: rtl/fib_capture_fifo_if.sv
// Wishbone classic slave bundle for the fibonacci capture buffer.
interface fib_capture_fifo_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fib_capture_fifo.sv
// Captures each stable new value of the fibonacci counter into a FIFO that
// firmware drains over Wishbone; interrupts on fill threshold or overflow.
module fib_capture_fifo #(
    parameter int unsigned WIDTH     = 30,
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic              wb_clk_i,
    input  logic              reset_n,
    fib_capture_fifo_if.slave wbs,
    input  logic [WIDTH-1:0]  value_i,
    output logic              irq_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d, en_q, en_d;
    logic [7:0]       thr_q, thr_d;
    logic             ack_q, ack_d, irq_q, irq_d;
    logic [31:0]      dat_q, dat_d;
    logic [WIDTH-1:0] sample_q, last_q, last_d;

    logic        hit_data, hit_stat, hit_ctrl, req, wr_en;
    logic        empty, full, pop, push_req, push, clear, ovf_set;
    logic [15:0] count_w;
    logic [31:0] rdata;
    logic        unused_bits;

    assign hit_data = (wbs.wbs_adr_i == BASE_ADDR);
    assign hit_stat = (wbs.wbs_adr_i == BASE_ADDR + 32'd4);
    assign hit_ctrl = (wbs.wbs_adr_i == BASE_ADDR + 32'd8);
    assign req      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q & (hit_data | hit_stat | hit_ctrl);
    assign wr_en    = req & wbs.wbs_we_i & (wbs.wbs_sel_i == 4'hF);

    assign count_w  = 16'(count_q);
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign pop      = req & ~wbs.wbs_we_i & hit_data & ~empty;
    // A value must be seen on two consecutive edges before it counts as new.
    assign push_req = en_q & (value_i == sample_q) & (value_i != last_q);
    assign clear    = wr_en & hit_ctrl & wbs.wbs_dat_i[1];
    assign push     = push_req & (~full | pop) & ~clear;
    assign ovf_set  = push_req & full & ~pop;

    assign unused_bits = ^{wbs.wbs_dat_i[31:19], wbs.wbs_dat_i[17:16], wbs.wbs_dat_i[7:2]};

    always_comb begin
        rdata = '0;
        if (hit_data) begin
            rdata = empty ? 32'h8000_0000 : 32'(mem_q[rd_ptr_q]);
        end else if (hit_stat) begin
            rdata = {13'd0, ovf_q, full, empty, count_w};
        end else if (hit_ctrl) begin
            rdata = {16'd0, thr_q, 7'd0, en_q};
        end
    end

    always_comb begin
        en_d     = en_q;
        thr_d    = thr_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = push_req ? value_i : last_q;

        if (wr_en && hit_ctrl) begin
            en_d  = wbs.wbs_dat_i[0];
            thr_d = wbs.wbs_dat_i[15:8];
        end

        if (clear) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            // A fresh overflow event outranks a simultaneous firmware clear.
            if (wr_en && hit_stat && wbs.wbs_dat_i[18]) ovf_d = 1'b0;
            if (ovf_set) ovf_d = 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);
        end

        ack_d = req;
        dat_d = (req && !wbs.wbs_we_i) ? rdata : '0;
        irq_d = ((thr_q != 8'd0) && (count_w >= {8'd0, thr_q})) || ovf_q;
    end

    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            en_q     <= 1'b0;
            thr_q    <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sample_q <= '0;
            last_q   <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            thr_q    <= thr_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sample_q <= value_i;
            last_q   <= last_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= value_i;
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_fib_capture_fifo.sv
// Bench for fib_capture_fifo: register vector table, directed corner cases and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_fib_capture_fifo;
    localparam int          WIDTH  = 30;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h3000_0100;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] value;
    logic             irq;

    fib_capture_fifo_if bus();

    fib_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .reset_n  (rst_n),
        .wbs      (bus),
        .value_i  (value),
        .irq_o    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntot = 0;
    int nbad = 0;

    // reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_prev, m_last;
    bit               m_ovf, m_en, m_ack, m_irq, m_chkdat;
    logic [7:0]       m_thr;
    logic [31:0]      m_dat;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev = '0; m_last = '0;
        m_ovf = 0; m_en = 0; m_ack = 0; m_irq = 0; m_chkdat = 1;
        m_thr = '0; m_dat = '0;
    endtask

    // Advances the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        bit          match, acc, wok, push, pop, irq_n;
        logic [31:0] rd;
        match = (bus.wbs_adr_i == A_DATA) || (bus.wbs_adr_i == A_STAT) || (bus.wbs_adr_i == A_CTRL);
        acc   = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack && match;
        wok   = acc && bus.wbs_we_i && (bus.wbs_sel_i == 4'hF);
        rd    = '0;
        if (bus.wbs_adr_i == A_DATA)
            rd = (mq.size() > 0) ? 32'(mq[0]) : 32'h8000_0000;
        else if (bus.wbs_adr_i == A_STAT)
            rd = {13'd0, m_ovf, mq.size() == DEPTH, mq.size() == 0, 16'(mq.size())};
        else if (bus.wbs_adr_i == A_CTRL)
            rd = {16'd0, m_thr, 7'd0, m_en};
        pop   = acc && !bus.wbs_we_i && (bus.wbs_adr_i == A_DATA) && (mq.size() > 0);
        push  = m_en && (value == m_prev) && (value != m_last);
        irq_n = ((m_thr != 0) && (mq.size() >= int'(m_thr))) || m_ovf;
        if (push) m_last = value;
        if (wok && bus.wbs_adr_i == A_CTRL) begin
            m_en  = bus.wbs_dat_i[0];
            m_thr = bus.wbs_dat_i[15:8];
        end
        if (wok && bus.wbs_adr_i == A_CTRL && bus.wbs_dat_i[1]) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            if (wok && bus.wbs_adr_i == A_STAT && bus.wbs_dat_i[18]) m_ovf = 0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(value);
                else m_ovf = 1;
            end
        end
        m_ack    = acc;
        m_chkdat = !(acc && bus.wbs_we_i);
        m_dat    = (acc && !bus.wbs_we_i) ? rd : '0;
        m_irq    = irq_n;
        m_prev   = value;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("ack", 32'(bus.wbs_ack_o), 32'(m_ack));
        if (m_chkdat) check("dat_o", bus.wbs_dat_o, m_dat);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic bus_access(input bit w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, output logic [31:0] r);
        bit got;
        got = 0;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = w;
        bus.wbs_adr_i = a; bus.wbs_sel_i = s; bus.wbs_dat_i = d;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (bus.wbs_ack_o) got = 1;
        end
        r = bus.wbs_dat_o;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        check("bus_ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
        bus_access(0, a, 4'hF, 32'd0, r);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_access(1, a, 4'hF, d, r);
    endtask

    task automatic hold(input logic [WIDTH-1:0] v, input int n);
        value = v;
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        vt[0]  = '{0, A_CTRL, 4'hF, 32'h0,        32'h0};
        vt[1]  = '{0, A_STAT, 4'hF, 32'h0,        32'h0001_0000};
        vt[2]  = '{0, A_DATA, 4'hF, 32'h0,        32'h8000_0000};
        vt[3]  = '{1, A_CTRL, 4'hF, 32'h0000_0301, 32'h0};
        vt[4]  = '{0, A_CTRL, 4'hF, 32'h0,        32'h0000_0301};
        vt[5]  = '{1, A_CTRL, 4'h3, 32'h0,        32'h0};
        vt[6]  = '{0, A_CTRL, 4'hF, 32'h0,        32'h0000_0301};
        vt[7]  = '{1, A_CTRL, 4'hF, 32'h0000_0503, 32'h0};
        vt[8]  = '{0, A_CTRL, 4'hF, 32'h0,        32'h0000_0501};
        vt[9]  = '{1, A_DATA, 4'hF, 32'h0000_1234, 32'h0};
        vt[10] = '{0, A_STAT, 4'hF, 32'h0,        32'h0001_0000};
        vt[11] = '{1, A_CTRL, 4'hF, 32'h0,        32'h0};
        vt[12] = '{0, A_CTRL, 4'hF, 32'h0,        32'h0};

        rst_n = 0; value = '0;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            bus_access(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, r);
            if (!vt[i].we) check($sformatf("vec%0d", i), r, vt[i].exp);
        end

        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = BASE + 32'd12;
        repeat (3) begin
            tick();
            check("nomatch_ack", 32'(bus.wbs_ack_o), 32'd0);
        end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;

        // basic fibonacci capture
        bus_wr(A_CTRL, 32'h1);
        hold(1, 4); hold(1, 4); hold(2, 4); hold(3, 4); hold(5, 4);
        bus_rd(A_STAT, r); check("fib_status", r, 32'h0000_0004);
        bus_rd(A_DATA, r); check("fib_d0", r, 32'd1);
        bus_rd(A_DATA, r); check("fib_d1", r, 32'd2);
        bus_rd(A_DATA, r); check("fib_d2", r, 32'd3);
        bus_rd(A_DATA, r); check("fib_d3", r, 32'd5);
        bus_rd(A_DATA, r); check("fib_empty", r, 32'h8000_0000);

        // one-cycle glitch is filtered
        hold(3, 4); hold(7, 1); hold(5, 4);
        bus_rd(A_STAT, r); check("glitch_count", r, 32'h0000_0002);
        bus_rd(A_DATA, r); check("glitch_d0", r, 32'd3);
        bus_rd(A_DATA, r); check("glitch_d1", r, 32'd5);

        // overflow
        for (int i = 0; i < 17; i++) hold(WIDTH'(100 + i), 3);
        bus_rd(A_STAT, r); check("ovf_status", r, 32'h0006_0010);
        check("ovf_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++) begin
            bus_rd(A_DATA, r); check("ovf_drain", r, 32'(100 + i));
        end
        bus_wr(A_STAT, 32'h0004_0000);
        bus_rd(A_STAT, r); check("ovf_cleared", r, 32'h0001_0000);

        // threshold interrupt timing
        bus_wr(A_CTRL, 32'h0000_0401);
        hold(200, 3); hold(201, 3); hold(202, 3);
        value = 203;
        tick(); tick();
        check("thr_irq_pre", 32'(irq), 32'd0);
        tick();
        check("thr_irq_rise", 32'(irq), 32'd1);
        bus_rd(A_DATA, r); check("thr_d0", r, 32'd200);
        check("thr_irq_hold", 32'(irq), 32'd1);
        tick();
        check("thr_irq_fall", 32'(irq), 32'd0);
        for (int i = 1; i < 4; i++) begin
            bus_rd(A_DATA, r); check("thr_drain", r, 32'(200 + i));
        end
        bus_wr(A_CTRL, 32'h1);

        // full FIFO: pop and push on the same edge
        for (int i = 0; i < 16; i++) hold(WIDTH'(300 + i), 3);
        value = 316;
        tick();
        bus_rd(A_DATA, r); check("full_pp_d0", r, 32'd300);
        bus_rd(A_STAT, r); check("full_pp_status", r, 32'h0002_0010);
        for (int i = 0; i < 16; i++) begin
            bus_rd(A_DATA, r); check("full_pp_drain", r, 32'(301 + i));
        end

        // clear on a push edge
        hold(400, 3); hold(401, 3);
        value = 402;
        tick();
        bus_wr(A_CTRL, 32'h3);
        bus_rd(A_STAT, r); check("clear_status", r, 32'h0001_0000);
        bus_rd(A_DATA, r); check("clear_data", r, 32'h8000_0000);

        // reset in the middle of a read
        bus_wr(A_CTRL, 32'h0000_0101);
        hold(500, 3); hold(501, 3);
        check("pre_rst_irq", 32'(irq), 32'd1);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
        bus.wbs_adr_i = A_DATA; bus.wbs_sel_i = 4'hF;
        tick();
        check("midrd_ack", 32'(bus.wbs_ack_o), 32'd1);
        #2 rst_n = 0;
        #1;
        check("async_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("async_dat", bus.wbs_dat_o, 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        model_reset();
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        #3 rst_n = 1;
        bus_rd(A_CTRL, r); check("post_rst_ctrl", r, 32'h0);
        bus_rd(A_STAT, r); check("post_rst_stat", r, 32'h0001_0000);
        bus_rd(A_DATA, r); check("post_rst_data", r, 32'h8000_0000);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int unsigned sel_a;
            if ($urandom_range(0, 9) < 4) value = WIDTH'($urandom_range(0, 5));
            bus.wbs_cyc_i = ($urandom_range(0, 3) != 0);
            bus.wbs_stb_i = $urandom_range(0, 1) == 1;
            bus.wbs_we_i  = $urandom_range(0, 2) == 0;
            bus.wbs_sel_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            sel_a = $urandom_range(0, 9);
            if (sel_a < 4)       bus.wbs_adr_i = A_DATA;
            else if (sel_a < 6)  bus.wbs_adr_i = A_STAT;
            else if (sel_a < 8)  bus.wbs_adr_i = A_CTRL;
            else if (sel_a == 8) bus.wbs_adr_i = BASE + 32'd12;
            else                 bus.wbs_adr_i = A_STAT + 32'h1000;
            if (bus.wbs_adr_i == A_CTRL)
                bus.wbs_dat_i = {16'd0, 8'($urandom_range(0, 20)), 6'd0,
                                 $urandom_range(0, 11) == 0, $urandom_range(0, 7) != 0};
            else
                bus.wbs_dat_i = $urandom;
            tick();
        end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        tick();

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule

// File: doc/fib_capture_fifo.md
# fib_capture_fifo

Wishbone-readable capture buffer that sits directly downstream of the fibonacci counter. It watches the counter's parallel output, records each new stable value into a FIFO, and lets firmware drain the sequence over Wishbone. It raises an interrupt on a fill threshold or on overflow. It shares the Wishbone bus with the other user-project slaves and responds only to its own three addresses.

## Interface
- WIDTH, 30, width of the captured value; must be ≤ 31
- DEPTH, 16, FIFO entries; power of two, 2..256
- BASE_ADDR, 32'h3000_0100, word address of register 0; registers at +0, +4, +8
- wb_clk_i  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid only while wbs_ack_o=1, else 0
- value_i  in  WIDTH  fibonacci counter output; may change at any wb_clk_i edge
- irq_o  out  1  registered level interrupt

## Operation
- Registers:
  - DATA, at +0, read-only.
    - Non-empty: returns {zeros, head} and pops the head.
    - Empty: returns 32'h8000_0000 and does not pop.
  - STATUS, at +4.
    - Read fields: [15:0] count, [16] empty, [17] full, [18] overflow (sticky).
    - Write with dat[18]=1 clears overflow.
  - CTRL, at +8.
    - [0] enable, reset 0.
    - [15:8] threshold, reset 0.
    - [1] clear: write 1 flushes the FIFO and clears overflow. Self-clearing; reads as 0.
- Write byte lanes: a write is applied only when wbs_sel_i=4'hF. Any other select pattern is still acknowledged but has no effect.
- Capture filter:
  - Register sample_q <= value_i every cycle.
  - A push fires when enable=1 && value_i==sample_q && value_i!=last_q.
  - On a push, last_q <= value_i. Values held for only 1 cycle are never captured.
  - last_q resets to 0, so the post-reset 0 is not captured.
- Full behaviour: a push while full without a concurrent pop is dropped and sets overflow; last_q still updates.
- Simultaneous push and pop: both occur and count is unchanged. This applies when full too: no overflow is set.
- clear coinciding with a push or pop: clear wins; count becomes 0.
- Disabling (enable 1→0): FIFO contents are retained and reads continue.
- irq_o <= (threshold!=0 && count>=threshold) || overflow.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is a separate log2(DEPTH)+1-bit counter, 0..DEPTH.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - count=0, overflow=0, enable=0, threshold=0, sample_q=0, last_q=0.
- Bus request: cyc && stb && !wbs_ack_o && the address matches one of the three registers. Unmatched addresses are never acknowledged.
- Request accepted at edge N:
  - wbs_ack_o=1 and wbs_dat_o are valid during cycle N+1.
  - The pop or register write takes effect at edge N.
  - wbs_ack_o drops at edge N+1.
  - Maximum throughput is one access per 2 cycles.
- Capture latency:
  - value_i changes before edge K and is held: sample_q matches at edge K, and the push occurs at edge K+1.
  - count is visible from cycle K+2.
- irq_o is 1 cycle after the count/overflow change that causes it.
- reset_n low mid-transaction: ack drops asynchronously and the transaction is abandoned.

## Test plan
- Reset, enable=1, value_i steps 1,1,2,3,5, each held 4 cycles -> STATUS count=4. DATA reads return 1,2,3,5, then 32'h8000_0000.
- value_i glitches to 7 for 1 cycle between held 3 and 5 -> 7 is never stored; FIFO holds 3,5.
- DEPTH=16: push 17 distinct values without reading -> count=16, full=1, overflow=1, irq_o=1. DATA returns the first 16 values. Writing STATUS 32'h0004_0000 -> overflow=0.
- threshold=4 -> irq_o rises 1 cycle after the 4th push. One DATA read -> irq_o falls 1 cycle after count=3.
- Full FIFO, a DATA read accepted on the same edge as a push -> count stays 16, overflow=0. The new value appears last after draining.
- CTRL write with clear=1 on a push edge -> count=0, empty=1, overflow=0. Assert reset_n=0 mid-read -> wbs_ack_o=0 at once and all registers return to their reset values.
